// File: rtl/sdr_stream_pkg.sv
// Shared types and width helpers for the chunked SDRAM read streamer.
package sdr_stream_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int chunk_of(input int data_w, input int word_w);
        return data_w / word_w;
    endfunction

    function automatic int chunk_bytes(input int data_w, input int word_w);
        return chunk_of(data_w, word_w) * word_w / 8;
    endfunction

    // Word-index width inside one chunk; never narrower than one bit.
    function automatic int idx_w(input int chunk);
        return (chunk > 1) ? $clog2(chunk) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit width_ok(input int data_w, input int word_w);
        return (word_w > 0) && (data_w % word_w == 0);
    endfunction

endpackage

// File: rtl/sdr_chunk_buf.sv
// Chunk capture register loaded from the bridge, with an indexed word select.
module sdr_chunk_buf
    import sdr_stream_pkg::*;
#(
    parameter int DATA_W = 2048,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [WORD_W-1:0] word_o
);

    logic [DATA_W-1:0] buf_q;

    // NOTE: pure data register with no reset; the top masks word_data outside STREAM,
    // so stale contents are never visible and an abort leaves them in place.
    always_ff @(posedge clk) begin
        if (load_i) begin
            buf_q <= data_i;
        end
    end

    assign word_o = buf_q[WORD_W*idx_i +: WORD_W];

endmodule

// File: rtl/sdr_chunk_streamer.sv
// Splits a read of any length into bridge-sized chunks and streams each chunk out word by word.
module sdr_chunk_streamer
    import sdr_stream_pkg::*;
#(
    parameter int DATA_W      = 2048,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NELEM_W     = 30,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               sdr_clk,
    input  logic               sdr_reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [NELEM_W-1:0] total_elems,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic               sdr_readstart,
    output logic [ADDR_W-1:0]  sdr_baseaddr,
    output logic [NELEM_W-1:0] sdr_nelems,
    input  logic               sdr_readend,
    input  logic [DATA_W-1:0]  sdr_readdata,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [WORD_W-1:0]  word_data,
    output logic [NELEM_W-1:0] word_idx,
    output logic               word_last
);

    localparam int CHUNK = chunk_of(DATA_W, WORD_W);
    localparam int CBYTES = chunk_bytes(DATA_W, WORD_W);
    localparam int IDX_W = idx_w(CHUNK);
    localparam int TMO_W = cnt_w(TIMEOUT_CYC);
    localparam logic [NELEM_W-1:0] CHUNK_N = NELEM_W'(CHUNK);

    if (!width_ok(DATA_W, WORD_W)) begin : g_bad_width
        $error("sdr_chunk_streamer: DATA_W must be a multiple of WORD_W");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NELEM_W-1:0]  rem_q, rem_d;
    logic [NELEM_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                buf_load;
    logic [WORD_W-1:0]   buf_word;
    logic                chunk_end;
    logic                tmo_hit;
    logic                in_req;

    assign chunk_end = (k_q == IDX_W'(CHUNK - 1));
    assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    sdr_chunk_buf #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk    (sdr_clk),
        .load_i (buf_load),
        .data_i (sdr_readdata),
        .idx_i  (k_q),
        .word_o (buf_word)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        k_d      = k_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        done_d   = 1'b0;
        buf_load = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d = 1'b0;
                        if (total_elems != '0) begin
                            addr_d  = base_addr;
                            rem_d   = total_elems;
                            idx_d   = '0;
                            state_d = ISSUE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    // A readend arriving on the timeout cycle still completes the chunk.
                    if (sdr_readend) begin
                        buf_load = 1'b1;
                        k_d      = '0;
                        state_d  = STREAM;
                    end else if (tmo_hit) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                STREAM: begin
                    if (word_ready) begin
                        k_d   = k_q + IDX_W'(1);
                        idx_d = idx_q + NELEM_W'(1);
                        rem_d = rem_q - NELEM_W'(1);
                        if (rem_q == NELEM_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else if (chunk_end) begin
                            addr_d  = addr_q + ADDR_W'(CBYTES);
                            state_d = ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge sdr_clk or negedge sdr_reset_n) begin
        if (!sdr_reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign in_req        = (state_q == ISSUE) || (state_q == WAIT);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err_timeout   = err_q;
    assign sdr_readstart = (state_q == ISSUE);
    assign sdr_baseaddr  = in_req ? addr_q : '0;
    assign sdr_nelems    = in_req ? ((rem_q < CHUNK_N) ? rem_q : CHUNK_N) : '0;
    assign word_valid    = (state_q == STREAM);
    assign word_data     = word_valid ? buf_word : '0;
    assign word_idx      = word_valid ? idx_q : '0;
    assign word_last     = word_valid && (rem_q == NELEM_W'(1));

endmodule

// File: tb/tb_sdr_chunk_streamer.sv
// Directed bench for sdr_chunk_streamer: bridge model, stream monitor, one task per scenario.
module tb_sdr_chunk_streamer;

    localparam int DATA_W  = 2048;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int NELEM_W = 30;
    localparam int CHUNK   = 64;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  base_addr;
    logic [NELEM_W-1:0] total_elems;
    logic               busy;
    logic               done;
    logic               err_timeout;
    logic               sdr_readstart;
    logic [ADDR_W-1:0]  sdr_baseaddr;
    logic [NELEM_W-1:0] sdr_nelems;
    logic               sdr_readend;
    logic [DATA_W-1:0]  sdr_readdata;
    logic               word_valid;
    logic               word_ready;
    logic [WORD_W-1:0]  word_data;
    logic [NELEM_W-1:0] word_idx;
    logic               word_last;

    sdr_chunk_streamer #(
        .DATA_W      (DATA_W),
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W),
        .NELEM_W     (NELEM_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .sdr_clk       (clk),
        .sdr_reset_n   (rst_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .total_elems   (total_elems),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .sdr_readstart (sdr_readstart),
        .sdr_baseaddr  (sdr_baseaddr),
        .sdr_nelems    (sdr_nelems),
        .sdr_readend   (sdr_readend),
        .sdr_readdata  (sdr_readdata),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .word_idx      (word_idx),
        .word_last     (word_last)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Bench controls
    logic [ADDR_W-1:0] tb_base = '0;
    bit bridge_en  = 1'b1;
    bit rand_ready = 1'b0;
    bit ready_fix  = 1'b1;
    int start_cyc  = 0;

    // Logs filled by the bridge model and stream monitor
    logic [ADDR_W-1:0]  req_addr[$];
    logic [NELEM_W-1:0] req_n[$];
    int                 req_cyc[$];
    logic [WORD_W-1:0]  w_data[$];
    int                 w_idx[$];
    int                 w_cyc[$];
    int last_cnt, last_pos, last_cyc;
    int done_cnt, done_cyc, err_cyc, valid_cnt, stall_viol;
    logic               p_stall;
    logic [WORD_W-1:0]  p_data;
    logic [NELEM_W-1:0] p_idx;
    logic               p_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            word_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Bridge: answers each readstart two cycles later; element k of chunk at byte A is 0xA000 + (A-base)/4 + k.
    initial begin
        logic [ADDR_W-1:0]  a;
        logic [NELEM_W-1:0] n;
        logic [DATA_W-1:0]  d;
        sdr_readend  = 1'b0;
        sdr_readdata = '0;
        forever begin
            @(negedge clk);
            if (sdr_readstart) begin
                a = sdr_baseaddr;
                n = sdr_nelems;
                req_addr.push_back(a);
                req_n.push_back(n);
                req_cyc.push_back(cyc);
                if (bridge_en) begin
                    for (int k = 0; k < CHUNK; k++) begin
                        d[WORD_W*k +: WORD_W] = (k < int'(n)) ?
                            32'(32'hA000 + ((a - tb_base) >> 2) + 32'(k)) : 32'(32'hDEAD0000 + k);
                    end
                    @(posedge clk);
                    #1;
                    @(posedge clk);
                    #1;
                    sdr_readend  = 1'b1;
                    sdr_readdata = d;
                    @(posedge clk);
                    #1;
                    sdr_readend  = 1'b0;
                    sdr_readdata = '0;
                end
            end
        end
    end

    initial begin
        p_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (word_valid && word_ready) begin
                w_data.push_back(word_data);
                w_idx.push_back(int'(word_idx));
                w_cyc.push_back(cyc);
                if (word_last) begin
                    last_cnt++;
                    last_pos = int'(word_idx);
                    last_cyc = cyc;
                end
            end
            if (word_valid) valid_cnt++;
            if (p_stall && word_valid &&
                (word_data !== p_data || word_idx !== p_idx || word_last !== p_last)) stall_viol++;
            p_stall = rst_n && word_valid && !word_ready;
            p_data  = word_data;
            p_idx   = word_idx;
            p_last  = word_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_timeout && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic clear_logs();
        req_addr.delete(); req_n.delete(); req_cyc.delete();
        w_data.delete(); w_idx.delete(); w_cyc.delete();
        last_cnt = 0; last_pos = -1; last_cyc = -1;
        done_cnt = 0; done_cyc = -1; err_cyc = -1;
        valid_cnt = 0; stall_viol = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [NELEM_W-1:0] t);
        @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = b;
        total_elems = t;
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick(1);
            i++;
        end
        n_chk++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
        tick(3);
    endtask

    function automatic int count_bad_words(input int n);
        int bad;
        bad = 0;
        if (w_data.size() != n) return n + 1;
        for (int i = 0; i < n; i++) begin
            if (w_data[i] !== 32'(32'hA000 + i) || w_idx[i] != i) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        start = 1'b0; abort = 1'b0; base_addr = '0; total_elems = '0;
        rst_n = 1'b0;
        clear_logs();
        tick(3);
        n_chk++;
        if ({busy, done, err_timeout, sdr_readstart, word_valid, word_last} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, err_timeout, sdr_readstart, word_valid, word_last});
        end
        n_chk++;
        if ({sdr_baseaddr, sdr_nelems, word_data, word_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_buses: addr=%0h nelems=%0d data=%0h idx=%0d want all 0",
                     sdr_baseaddr, sdr_nelems, word_data, word_idx);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_chunk();
        clear_logs();
        tb_base = 32'h1000;
        pulse_start(32'h1000, 64);
        wait_done("single_done", 400);
        n_chk++;
        if (req_addr.size() != 1 || req_addr[0] !== 32'h1000 || req_n[0] !== 30'd64) begin
            n_err++;
            $display("FAIL single_req: count=%0d addr=%0h n=%0d want 1/1000/64", req_addr.size(),
                     (req_addr.size() > 0) ? req_addr[0] : '0, (req_n.size() > 0) ? req_n[0] : '0);
        end
        n_chk++;
        if (count_bad_words(64) != 0) begin
            n_err++;
            $display("FAIL single_words: bad=%0d of %0d got, want 64 words A000..A03F",
                     count_bad_words(64), w_data.size());
        end
        n_chk++;
        if (last_cnt != 1 || last_pos != 63) begin
            n_err++;
            $display("FAIL single_last: count=%0d pos=%0d want 1 at 63", last_cnt, last_pos);
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
            n_err++;
            $display("FAIL single_done_time: count=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, last_cyc + 1);
        end
        n_chk++;
        if (w_cyc.size() != 64 || w_cyc[63] - w_cyc[0] != 63) begin
            n_err++;
            $display("FAIL single_rate: words=%0d span=%0d want 64 words over 63 cycles", w_cyc.size(),
                     (w_cyc.size() == 64) ? w_cyc[63] - w_cyc[0] : -1);
        end
    endtask

    task automatic check_150(input string name);
        n_chk++;
        if (req_addr.size() != 3 || req_addr[0] !== 32'h000 || req_addr[1] !== 32'h100 || req_addr[2] !== 32'h200) begin
            n_err++;
            $display("FAIL %s_addrs: count=%0d want 3 reads at 000,100,200", name, req_addr.size());
        end
        n_chk++;
        if (req_n.size() != 3 || req_n[0] !== 30'd64 || req_n[1] !== 30'd64 || req_n[2] !== 30'd22) begin
            n_err++;
            $display("FAIL %s_nelems: count=%0d want 64,64,22", name, req_n.size());
        end
        n_chk++;
        if (count_bad_words(150) != 0) begin
            n_err++;
            $display("FAIL %s_words: bad=%0d got %0d want idx 0..149 data A000+idx", name,
                     count_bad_words(150), w_data.size());
        end
        n_chk++;
        if (last_cnt != 1 || last_pos != 149 || done_cnt != 1) begin
            n_err++;
            $display("FAIL %s_end: last=%0d@%0d done=%0d want 1@149 done=1", name, last_cnt, last_pos, done_cnt);
        end
    endtask

    task automatic test_multi_chunk();
        clear_logs();
        tb_base = '0;
        pulse_start('0, 150);
        wait_done("multi_done", 1000);
        check_150("multi");
    endtask

    task automatic test_backpressure();
        clear_logs();
        tb_base = '0;
        rand_ready = 1'b1;
        pulse_start('0, 150);
        wait_done("stall_done", 3000);
        rand_ready = 1'b0;
        check_150("stall");
        n_chk++;
        if (stall_viol != 0) begin
            n_err++;
            $display("FAIL stall_stable: violations=%0d want 0", stall_viol);
        end
    endtask

    task automatic test_timeout();
        int ic;
        clear_logs();
        bridge_en = 1'b0;
        pulse_start(32'h40, 64);
        wait_done("tmo_done", 200);
        ic = (req_cyc.size() > 0) ? req_cyc[0] : -100;
        n_chk++;
        if (err_cyc != ic + 17 || done_cyc != ic + 17 || done_cnt != 1) begin
            n_err++;
            $display("FAIL tmo_timing: err@%0d done@%0d x%0d want both @%0d once", err_cyc, done_cyc,
                     done_cnt, ic + 17);
        end
        n_chk++;
        if (valid_cnt != 0 || busy !== 1'b0 || err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_state: valid=%0d busy=%b err=%b want 0/0/1", valid_cnt, busy, err_timeout);
        end
        bridge_en = 1'b1;
        clear_logs();
        tb_base = 32'h3000;
        pulse_start(32'h3000, 64);
        n_chk++;
        if (err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_clear: err=%b want 0 after new start", err_timeout);
        end
        wait_done("tmo_rerun", 400);
        n_chk++;
        if (count_bad_words(64) != 0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_rerun_words: bad=%0d err=%b want 0/0", count_bad_words(64), err_timeout);
        end
    endtask

    task automatic test_zero_and_restart();
        int i;
        clear_logs();
        pulse_start(32'h500, 0);
        tick(3);
        n_chk++;
        if (done_cnt != 1 || done_cyc != start_cyc + 1 || req_addr.size() != 0 || valid_cnt != 0) begin
            n_err++;
            $display("FAIL zero_len: done=%0d@%0d reads=%0d valid=%0d want 1@%0d 0 0", done_cnt, done_cyc,
                     req_addr.size(), valid_cnt, start_cyc + 1);
        end
        clear_logs();
        tb_base = '0;
        pulse_start('0, 150);
        i = 0;
        while (w_data.size() < 5 && i < 100) begin
            tick(1);
            i++;
        end
        pulse_start(32'h8000, 3);
        wait_done("restart_done", 1000);
        check_150("restart");
    endtask

    task automatic test_abort_and_reset();
        int i;
        clear_logs();
        tb_base = '0;
        pulse_start('0, 150);
        i = 0;
        while (w_data.size() < 10 && i < 100) begin
            tick(1);
            i++;
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        n_chk++;
        if ({busy, word_valid, sdr_readstart, word_last} !== 4'b0 || word_data !== '0 || sdr_baseaddr !== '0) begin
            n_err++;
            $display("FAIL abort_idle: busy=%b valid=%b rs=%b data=%0h want all 0", busy, word_valid,
                     sdr_readstart, word_data);
        end
        tick(5);
        n_chk++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: done=%0d busy=%b want 0/0", done_cnt, busy);
        end
        clear_logs();
        tb_base = 32'h2000;
        pulse_start(32'h2000, 64);
        i = 0;
        while (req_addr.size() == 0 && i < 20) begin
            tick(1);
            i++;
        end
        rst_n = 1'b0;
        tick(3);
        n_chk++;
        if ({busy, done, sdr_readstart, word_valid} !== 4'b0 || sdr_baseaddr !== '0 || sdr_nelems !== '0) begin
            n_err++;
            $display("FAIL wait_reset: busy=%b done=%b rs=%b addr=%0h n=%0d want all 0", busy, done,
                     sdr_readstart, sdr_baseaddr, sdr_nelems);
        end
        rst_n = 1'b1;
        tick(5);
        n_chk++;
        if (done_cnt != 0 || busy !== 1'b0 || valid_cnt != 0) begin
            n_err++;
            $display("FAIL wait_reset_quiet: done=%0d busy=%b valid=%0d want 0", done_cnt, busy, valid_cnt);
        end
        clear_logs();
        pulse_start(32'h2000, 64);
        wait_done("fresh_done", 400);
        n_chk++;
        if (req_addr.size() != 1 || req_addr[0] !== 32'h2000 || count_bad_words(64) != 0 ||
            last_pos != 63 || done_cnt != 1) begin
            n_err++;
            $display("FAIL fresh_run: reads=%0d bad=%0d last=%0d done=%0d want 1/0/63/1", req_addr.size(),
                     count_bad_words(64), last_pos, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_backpressure();
        test_timeout();
        test_zero_and_restart();
        test_abort_and_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
